ball_competition: RTL and testbench

Two-team ball-game scoreboard for the FPGA board. It debounces four active-low push keys to add points and toggle serve. It runs an 8-segment LED countdown for the game period and shows each team's score, 0–9, on a dedicated 7-segment digit. When the game ends it flags the winner on the two team LEDs.

---
 rtl/ball_competition.sv | 125 ++++++++++++
 tb/tb_ball_competition.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ball_competition.sv
// ball_competition: two-team scoreboard with debounced keys, countdown timer and winner flag
module ball_competition #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int TICK_CYCLES     = 1000,
    parameter int WIN_SCORE       = 9
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] sw_in,
    input  logic [3:0] key_in,
    output logic [1:0] reg_ab,
    output logic [7:0] led_time,
    output logic [8:0] seg_led_1,
    output logic [8:0] seg_led_2
);
    localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX = TW'(TICK_CYCLES - 1);
    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    logic [3:0] sync1, sync2, press;
    logic [3:0] score_a, score_b, next_a, next_b;
    logic serve, game_over, next_serve, next_over;
    logic [TW-1:0] tick, next_tick;
    logic [7:0] next_led;
    logic [1:0] next_ab;
    logic run, tick_en, tick_wrap;
    logic [8:0] seg_a, seg_b;
    logic unused_sw;

    assign unused_sw = sw_in[3];

    // two-stage synchronizer; keys idle high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_key
        logic [DW-1:0] cnt;
        logic level;
        // accepted level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt   <= '0;
                level <= 1'b1;
            end else if (sync2[k] == level) begin
                cnt <= '0;
            end else if (cnt == D_MAX) begin
                cnt   <= '0;
                level <= sync2[k];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign press[k] = ~sync2[k] & level & (cnt == D_MAX);
    end

    assign run       = sw_in[0] & ~game_over;
    assign tick_en   = run & sw_in[1];
    assign tick_wrap = tick_en & (tick == T_MAX);

    // next game state; key3 overrides everything, winner/serve drive reg_ab
    always_comb begin
        next_a     = press[3] ? 4'd0 : (run & press[0] & (score_a != WIN)) ? score_a + 4'd1 : score_a;
        next_b     = press[3] ? 4'd0 : (run & press[1] & (score_b != WIN)) ? score_b + 4'd1 : score_b;
        next_serve = press[3] ? 1'b0 : (run & press[2]) ? ~serve : serve;
        next_tick  = press[3] ? '0 : tick_wrap ? '0 : tick_en ? tick + 1'b1 : tick;
        next_led   = press[3] ? 8'hFF : tick_wrap ? led_time >> 1 : led_time;
        next_over  = press[3] ? 1'b0 : game_over | (led_time == 8'h00) | (score_a == WIN) | (score_b == WIN);
        next_ab    = next_over ? ((next_a > next_b) ? 2'b10 : (next_b > next_a) ? 2'b01 : 2'b11)
                               : (next_serve ? 2'b01 : 2'b10);
    end

    // game state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            score_a   <= '0;
            score_b   <= '0;
            serve     <= 1'b0;
            game_over <= 1'b0;
            tick      <= '0;
            led_time  <= 8'hFF;
            reg_ab    <= 2'b10;
        end else begin
            score_a   <= next_a;
            score_b   <= next_b;
            serve     <= next_serve;
            game_over <= next_over;
            tick      <= next_tick;
            led_time  <= next_led;
            reg_ab    <= next_ab;
        end
    end

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'd0:    enc = 7'h3F;
            4'd1:    enc = 7'h06;
            4'd2:    enc = 7'h5B;
            4'd3:    enc = 7'h4F;
            4'd4:    enc = 7'h66;
            4'd5:    enc = 7'h6D;
            4'd6:    enc = 7'h7D;
            4'd7:    enc = 7'h07;
            4'd8:    enc = 7'h7F;
            4'd9:    enc = 7'h6F;
            default: enc = 7'h00;
        endcase
    endfunction

    // digit images with serve dot, optionally swapped between the two displays
    always_comb begin
        seg_a     = {1'b0, ~game_over & ~serve, enc(score_a)};
        seg_b     = {1'b0, ~game_over & serve, enc(score_b)};
        seg_led_1 = sw_in[2] ? seg_b : seg_a;
        seg_led_2 = sw_in[2] ? seg_a : seg_b;
    end
endmodule

// File: tb/tb_ball_competition.sv
// tb_ball_competition: scoreboard-driven check of scoring, serve, timer and game-over behaviour
module tb_ball_competition;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [3:0] sw_in = 4'b0000;
    logic [3:0] key_in = 4'hF;
    logic [1:0] reg_ab;
    logic [7:0] led_time;
    logic [8:0] seg_led_1, seg_led_2;

    int n_vec = 0;
    int n_bad = 0;
    logic [27:0] exp_q[$];
    string tag_q[$];
    logic [3:0] m_a, m_b;
    logic m_srv, m_go;
    logic [7:0] m_led;
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    ball_competition #(.DEBOUNCE_CYCLES(8), .TICK_CYCLES(1000), .WIN_SCORE(9)) dut (
        .clk(clk), .rstn(rstn), .sw_in(sw_in), .key_in(key_in),
        .reg_ab(reg_ab), .led_time(led_time), .seg_led_1(seg_led_1), .seg_led_2(seg_led_2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] seg(input logic [3:0] v, input logic dp);
        return {1'b0, dp, seg_tab[v]};
    endfunction

    task automatic model_reset();
        m_a = 0; m_b = 0; m_srv = 1'b0; m_go = 1'b0; m_led = 8'hFF;
    endtask

    task automatic push(input string tag);
        logic [1:0] ab;
        logic [8:0] sa, sb;
        ab = m_go ? ((m_a > m_b) ? 2'b10 : (m_b > m_a) ? 2'b01 : 2'b11) : (m_srv ? 2'b01 : 2'b10);
        sa = seg(m_a, !m_go && !m_srv);
        sb = seg(m_b, !m_go && m_srv);
        exp_q.push_back({ab, m_led, sw_in[2] ? sb : sa, sw_in[2] ? sa : sb});
        tag_q.push_back(tag);
    endtask

    task automatic compare();
        logic [27:0] e;
        string t;
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".reg_ab"}, {7'b0, reg_ab}, {7'b0, e[27:26]});
        check({t, ".led_time"}, {1'b0, led_time}, {1'b0, e[25:18]});
        check({t, ".seg1"}, seg_led_1, e[17:9]);
        check({t, ".seg2"}, seg_led_2, e[8:0]);
    endtask

    task automatic press(input int k, input int hold);
        key_in[k] = 1'b0;
        repeat (hold) @(posedge clk);
        key_in[k] = 1'b1;
        repeat (30) @(posedge clk);
    endtask

    task automatic model_press(input int k);
        if (k == 3) model_reset();
        else if (sw_in[0] && !m_go) begin
            if (k == 0 && m_a < 9) m_a++;
            if (k == 1 && m_b < 9) m_b++;
            if (k == 2) m_srv = !m_srv;
        end
        m_go = m_go | (m_a == 9) | (m_b == 9) | (m_led == 8'h00);
    endtask

    task automatic do_press(input int k, input string tag);
        press(k, 30);
        model_press(k);
        push(tag);
        compare();
    endtask

    initial begin
        logic [7:0] prev;
        int cyc;
        model_reset();
        #10 rstn = 1'b1;
        push("reset");
        compare();

        sw_in = 4'b0011;
        do_press(0, "a_plus");
        do_press(1, "b_plus");
        do_press(2, "serve");

        sw_in = 4'b0010;
        for (int k = 0; k < 3; k++) press(k, 30);
        push("run_off");
        compare();
        sw_in = 4'b0011;
        press(0, 5);
        press(1, 5);
        press(2, 5);
        push("glitch");
        compare();
        sw_in = 4'b0111;
        push("swap");
        compare();
        sw_in = 4'b0011;

        prev = led_time;
        cyc = 0;
        while (led_time != 8'h00 && cyc < 12000) begin
            @(negedge clk);
            if (led_time != prev) begin
                check("led_shift", {1'b0, led_time}, {1'b0, prev >> 1});
                prev = led_time;
            end
            cyc++;
        end
        m_led = 8'h00;
        m_go = 1'b1;
        repeat (2) @(posedge clk);
        push("expired");
        compare();
        do_press(0, "frozen_a");
        do_press(2, "frozen_serve");
        do_press(3, "new_game1");

        sw_in = 4'b0001;
        for (int i = 0; i < 9; i++) do_press(0, "a_run");
        do_press(1, "won_b_ignored");
        do_press(0, "won_a_sat");
        do_press(3, "new_game2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
